// File: rtl/spi_word_feeder.sv
// Buffers 32-bit command words and launches them one at a time into the SPI master. Write-to-enable is 2 cycles.
// Writes while full are dropped and flagged; SPI_CS paces launches, with a programmable gap and a start watchdog.
module spi_word_feeder #(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [31:0]            wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic [31:0]            ToSPI,
  output logic                   enable,
  input  logic                   SPI_CS,
  output logic                   busy,
  output logic                   overflow,
  output logic                   timeout_err,
  input  logic                   clr_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] to_cnt, to_cnt_nxt;
  logic [GW-1:0] gap_cnt, gap_cnt_nxt;
  logic [LW-1:0] level_nxt;
  logic          push, pop, to_evt, ovf_evt;

  // full is the registered value, so a write on the edge that frees a slot is still dropped
  assign push    = wr_en && !full;
  assign ovf_evt = wr_en && full;

  always_comb begin
    state_nxt   = state;
    to_cnt_nxt  = to_cnt;
    gap_cnt_nxt = gap_cnt;
    pop         = 1'b0;
    to_evt      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        to_cnt_nxt = '0;
        state_nxt  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!SPI_CS) begin
          state_nxt = WAIT_DONE;
        end else if (to_cnt == TW'(TIMEOUT)) begin
          // the word is abandoned, never retried
          to_evt    = 1'b1;
          state_nxt = IDLE;
        end else begin
          to_cnt_nxt = to_cnt + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (SPI_CS) begin
          if (GAP_CYCLES == 0) begin
            state_nxt = IDLE;
          end else begin
            gap_cnt_nxt = GW'(GAP_CYCLES);
            state_nxt   = GAP;
          end
        end
      end
      GAP: begin
        gap_cnt_nxt = gap_cnt - GW'(1);
        if (gap_cnt <= GW'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      ToSPI       <= '0;
      enable      <= 1'b0;
      busy        <= 1'b0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
    end else begin
      state   <= state_nxt;
      to_cnt  <= to_cnt_nxt;
      gap_cnt <= gap_cnt_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        ToSPI  <= mem[rd_ptr];
      end
      level       <= level_nxt;
      full        <= (level_nxt == LW'(DEPTH));
      empty       <= (level_nxt == '0);
      enable      <= (state_nxt == LAUNCH);
      busy        <= (state_nxt != IDLE);
      overflow    <= ovf_evt || (overflow && !clr_err);
      timeout_err <= to_evt || (timeout_err && !clr_err);
    end
  end

endmodule
